// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline sequencing controller for the five-stage MIPS core.
//            Resolves per-stage stall requests into the stage stall vector,
//            turns memory-stage exceptions / ERET into a one-cycle flush plus
//            a registered redirect PC, masks exceptions for a drain window
//            after each redirect, and runs a sticky stall watchdog.
// Options  : PIPE_CTRL_PERF_EN adds stall-cycle and flush-count counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
   parameter int          DRAIN_CYCLES  = 2,
   parameter int          STALL_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        stallreq_commit,
   input  logic        except_valid_i,
   input  logic        except_eret_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        new_pc_valid_o,
   output logic        stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles_o,
   output logic [31:0] perf_flush_count_o
`endif
);

   localparam logic [0:0]  S_RUN   = 1'b0;
   localparam logic [0:0]  S_DRAIN = 1'b1;

   localparam logic [3:0]  c_drain_load = 4'(DRAIN_CYCLES);
   localparam logic [15:0] c_timeout    = 16'(STALL_TIMEOUT);

   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic [3:0]  r_drain_cnt;
   logic [3:0]  w_drain_nxt;
   logic        w_take;
   logic [5:0]  w_stall_vec;
   logic        w_stalled;
   logic [31:0] r_new_pc;
   logic        r_new_pc_valid;
   logic [15:0] r_wd_cnt;
   logic        r_timeout;

   // State register and drain counter; reset aborts any drain in progress
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_RUN;
         r_drain_cnt <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   // Next state: an exception in RUN opens a drain window of DRAIN_CYCLES
   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain_cnt;
      case (r_state)
         S_RUN: begin
            if (except_valid_i) begin
               w_state_nxt = S_DRAIN;
               w_drain_nxt = c_drain_load;
            end
         end
         S_DRAIN: begin
            w_drain_nxt = r_drain_cnt - 4'd1;
            // The last drain cycle is the one that sees count 1
            if (r_drain_cnt <= 4'd1) begin
               w_state_nxt = S_RUN;
               w_drain_nxt = 4'd0;
            end
         end
         default: begin
            w_state_nxt = S_RUN;
            w_drain_nxt = 4'd0;
         end
      endcase
   end

   // Outputs: flush only from RUN, flush overrides stalls, reset forces zeros
   always_comb begin
      w_take = resetn && (r_state == S_RUN) && except_valid_i;

      // Highest requesting stage wins; stalling stage k holds stages 0..k
      w_stall_vec = 6'b000000;
      if (stallreq_commit)   w_stall_vec = 6'b111111;
      else if (stallreq_mem) w_stall_vec = 6'b011111;
      else if (stallreq_ex)  w_stall_vec = 6'b001111;
      else if (stallreq_id)  w_stall_vec = 6'b000111;
      else if (stallreq_if)  w_stall_vec = 6'b000011;

      flush_o = w_take;
      stall_o = (resetn && !w_take) ? w_stall_vec : 6'b000000;
   end

   assign w_stalled = |stall_o;

   // Redirect register: target captured at the flush edge, valid one cycle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_new_pc       <= 32'd0;
         r_new_pc_valid <= 1'b0;
      end else begin
         r_new_pc_valid <= w_take;
         if (w_take) begin
            r_new_pc <= except_eret_i ? cp0_epc_i : EXC_VECTOR;
         end
      end
   end

   // Watchdog: saturating run-length of stalled cycles with a sticky trip flag
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wd_cnt  <= 16'd0;
         r_timeout <= 1'b0;
      end else if (w_stalled) begin
         if (r_wd_cnt != c_timeout) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
         end
         // Trip on the edge where the count reaches the limit
         if (r_wd_cnt >= (c_timeout - 16'd1)) begin
            r_timeout <= 1'b1;
         end
      end else begin
         r_wd_cnt <= 16'd0;
      end
   end

   assign new_pc_o        = r_new_pc;
   assign new_pc_valid_o  = r_new_pc_valid;
   assign stall_timeout_o = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   // Free-running performance counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_perf_stall <= 32'd0;
         r_perf_flush <= 32'd0;
      end else begin
         if (w_stalled) r_perf_stall <= r_perf_stall + 32'd1;
         if (w_take)    r_perf_flush <= r_perf_flush + 32'd1;
      end
   end

   assign perf_stall_cycles_o = r_perf_stall;
   assign perf_flush_count_o  = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Scoreboard bench for pipe_ctrl. Stimulus pushes expected per-cycle
//            responses from a cycle-indexed reference model; a negedge monitor
//            pops and compares. Define PIPE_CTRL_PERF_EN to cover counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

   localparam logic [31:0] c_exc   = 32'hBFC00380;
   localparam int          c_drain = 2;
   localparam int          c_tmo   = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [4:0]  req = 5'd0;      // bit0 if .. bit4 commit
   logic        exc = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] epc = 32'd0;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        new_pc_valid_o;
   logic        stall_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cycles_o;
   logic [31:0] perf_flush_count_o;
`endif

   always #5 clk = ~clk;

   pipe_ctrl #(
      .EXC_VECTOR    (c_exc),
      .DRAIN_CYCLES  (c_drain),
      .STALL_TIMEOUT (c_tmo)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .stallreq_if     (req[0]),
      .stallreq_id     (req[1]),
      .stallreq_ex     (req[2]),
      .stallreq_mem    (req[3]),
      .stallreq_commit (req[4]),
      .except_valid_i  (exc),
      .except_eret_i   (eret),
      .cp0_epc_i       (epc),
      .stall_o         (stall_o),
      .flush_o         (flush_o),
      .new_pc_o        (new_pc_o),
      .new_pc_valid_o  (new_pc_valid_o),
      .stall_timeout_o (stall_timeout_o)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cycles_o (perf_stall_cycles_o),
      .perf_flush_count_o  (perf_flush_count_o)
`endif
   );

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        pcv;
      logic        to;
      logic [31:0] ps;
      logic [31:0] pf;
      bit          chk;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model, expressed in absolute cycle numbers
   longint      cyc = 0;
   longint      m_accept_from = 0;
   logic [31:0] m_pc = 32'd0;
   logic        m_pcv = 1'b0;
   logic        m_flag = 1'b0;
   int          m_run = 0;
   logic [31:0] m_ps = 32'd0;
   logic [31:0] m_pf = 32'd0;
   bit          m_known = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   // One cycle of stimulus; the expected response is queued for the monitor
   task automatic drive(input logic rn, input logic [4:0] r, input logic x,
                        input logic er, input logic [31:0] pc);
      exp_t        e;
      logic        take;
      logic [5:0]  sv;
      @(posedge clk);
      #1;
      resetn = rn; req = r; exc = x; eret = er; epc = pc;
      sv = 6'd0;
      for (int k = 0; k < 5; k++) begin
         if (r[k]) sv = 6'((1 << (k + 2)) - 1);
      end
      take = rn && x && (cyc >= m_accept_from);
      if (!rn || take) sv = 6'd0;
      e.stall = sv;   e.flush = take;
      e.pc    = m_pc; e.pcv   = m_pcv; e.to = m_flag;
      e.ps    = m_ps; e.pf    = m_pf;  e.chk = m_known;
      sb.push_back(e);
      if (!rn) begin
         m_pc = 32'd0; m_pcv = 1'b0; m_flag = 1'b0; m_run = 0;
         m_ps = 32'd0; m_pf = 32'd0; m_accept_from = cyc + 1; m_known = 1'b1;
      end else begin
         m_pcv = take;
         if (take) begin
            m_pc = er ? pc : c_exc;
            m_accept_from = cyc + 1 + c_drain;
         end
         if (sv != 6'd0) m_run++; else m_run = 0;
         if (m_run >= c_tmo) m_flag = 1'b1;
         if (sv != 6'd0) m_ps = m_ps + 32'd1;
         if (take)       m_pf = m_pf + 32'd1;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 5'd0, 1'b0, 1'b0, 32'd0);
   endtask

   // Monitor: outputs are presented every cycle, compared mid-cycle
   exp_t me;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         me = sb.pop_front();
         check("stall_o", {26'd0, stall_o}, {26'd0, me.stall});
         check("flush_o", {31'd0, flush_o}, {31'd0, me.flush});
         if (me.chk) begin
            check("new_pc_o",        new_pc_o,                  me.pc);
            check("new_pc_valid_o",  {31'd0, new_pc_valid_o},  {31'd0, me.pcv});
            check("stall_timeout_o", {31'd0, stall_timeout_o}, {31'd0, me.to});
`ifdef PIPE_CTRL_PERF_EN
            check("perf_stall_cycles_o", perf_stall_cycles_o, me.ps);
            check("perf_flush_count_o",  perf_flush_count_o,  me.pf);
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end of stimulus, expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      // Reset with competing requests and exception present
      for (int i = 0; i < 3; i++) drive(1'b0, 5'b01000, 1'b1, 1'b0, 32'd0);
      idle(3);
      // Priority: id+ex, then add commit
      drive(1'b1, 5'b00110, 1'b0, 1'b0, 32'd0);
      drive(1'b1, 5'b10110, 1'b0, 1'b0, 32'd0);
      idle(2);
      // Three-cycle stall stays below the watchdog limit
      for (int i = 0; i < 3; i++) drive(1'b1, 5'b00001, 1'b0, 1'b0, 32'd0);
      idle(2);
      // Exception with a concurrent mem stall
      drive(1'b1, 5'b01000, 1'b1, 1'b0, 32'd0);
      idle(3);
      // ERET then exception held high through the drain window
      drive(1'b1, 5'd0, 1'b1, 1'b1, 32'h80001234);
      for (int i = 0; i < 3; i++) drive(1'b1, 5'd0, 1'b1, 1'b0, 32'd0);
      idle(4);
      // Four-cycle stall trips the watchdog, flag stays sticky
      for (int i = 0; i < 4; i++) drive(1'b1, 5'b00001, 1'b0, 1'b0, 32'd0);
      idle(3);
      // Fresh reset, then 5 stalled cycles and 2 spaced exceptions
      drive(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
      drive(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) drive(1'b1, 5'b00001, 1'b0, 1'b0, 32'd0);
      idle(1);
      for (int i = 0; i < 2; i++) drive(1'b1, 5'b00100, 1'b0, 1'b0, 32'd0);
      idle(1);
      drive(1'b1, 5'd0, 1'b1, 1'b0, 32'd0);
      idle(4);
      drive(1'b1, 5'd0, 1'b1, 1'b1, 32'h8000_0040);
      idle(4);
      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] r;
         for (int k = 0; k < 5; k++) r[k] = ($urandom_range(0, 5) == 0);
         drive(($urandom_range(0, 199) != 0), r, ($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1)), $urandom);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
